// File: rtl/alu_system_control_unit.sv
// alu_system_control_unit
// Hardwired multi-cycle control unit for the ArithmeticLogicUnitSystem datapath.
// Fetches a 16-bit instruction in two byte cycles (low byte, then high byte),
// decodes it and drives every datapath select, function and enable line.
// Outputs are combinational from state, IR and Flags.
// Optional feature macro: CU_COND_BRANCH_EN enables BNE/BEQ; when undefined,
// opcodes 0x01 and 0x02 decode as NOP.
module alu_system_control_unit (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] IR,
   input  logic [3:0]  Flags,
   output logic [2:0]  RF_OutASel,
   output logic [2:0]  RF_OutBSel,
   output logic [2:0]  RF_FunSel,
   output logic [3:0]  RF_RegSel,
   output logic [3:0]  RF_ScrSel,
   output logic [4:0]  ALU_FunSel,
   output logic        ALU_WF,
   output logic [1:0]  ARF_OutCSel,
   output logic [1:0]  ARF_OutDSel,
   output logic [1:0]  ARF_FunSel,
   output logic [4:0]  ARF_RegSel,
   output logic        IR_LH,
   output logic        IR_Write,
   output logic        Mem_WR,
   output logic        Mem_CS,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic        MuxCSel,
   output logic        MuxDSel,
   output logic [1:0]  DR_FunSel,
   output logic        DR_E,
   output logic        Halted
);

   localparam int unsigned OPC_W = 6;
   localparam int unsigned RSEL_W = 2;
   localparam int unsigned RF_W  = 4;

   // Opcodes
   localparam logic [OPC_W-1:0] OP_BRA  = 6'h00;
   localparam logic [OPC_W-1:0] OP_BNE  = 6'h01;
   localparam logic [OPC_W-1:0] OP_BEQ  = 6'h02;
   localparam logic [OPC_W-1:0] OP_INC  = 6'h03;
   localparam logic [OPC_W-1:0] OP_DEC  = 6'h04;
   localparam logic [OPC_W-1:0] OP_ADD  = 6'h05;
   localparam logic [OPC_W-1:0] OP_SUB  = 6'h06;
   localparam logic [OPC_W-1:0] OP_AND  = 6'h07;
   localparam logic [OPC_W-1:0] OP_ORR  = 6'h08;
   localparam logic [OPC_W-1:0] OP_XOR  = 6'h09;
   localparam logic [OPC_W-1:0] OP_MOVL = 6'h0A;
   localparam logic [OPC_W-1:0] OP_HLT  = 6'h0B;

   // ALU function codes
   localparam logic [4:0] ALU_PASS_A = 5'b10000;
   localparam logic [4:0] ALU_ADD    = 5'b10100;
   localparam logic [4:0] ALU_SUB    = 5'b10110;
   localparam logic [4:0] ALU_AND    = 5'b10111;
   localparam logic [4:0] ALU_OR     = 5'b11000;
   localparam logic [4:0] ALU_XOR    = 5'b11001;

   // Register-file and address-register-file function codes
   localparam logic [2:0] RF_DEC  = 3'b000;
   localparam logic [2:0] RF_INC  = 3'b001;
   localparam logic [2:0] RF_LOAD = 3'b010;
   localparam logic [1:0] ARF_INC  = 2'b01;
   localparam logic [1:0] ARF_LOAD = 2'b10;
   localparam logic [4:0] ARF_PC   = 5'b00001;

   // Mux source selects
   localparam logic [1:0] MUX_ALUOUT = 2'b00;
   localparam logic [1:0] MUX_IR_LO  = 2'b11;

   typedef enum logic [2:0] {
      S_FETCH_L = 3'd0,
      S_FETCH_H = 3'd1,
      S_EXEC    = 3'd2,
      S_EXEC2   = 3'd3,
      S_HALT    = 3'd4
   } state_t;

   state_t state;
   state_t state_next;

   // Instruction fields
   logic [OPC_W-1:0]  opcode;
   logic [RSEL_W-1:0] dst;
   logic [RSEL_W-1:0] src1;
   logic [RSEL_W-1:0] src2;
   logic [RSEL_W-1:0] rsel;
   logic              take_branch;
   logic              unused_bits;

   assign opcode = IR[15:10];
   assign rsel   = IR[9:8];
   assign dst    = IR[5:4];
   assign src1   = IR[3:2];
   assign src2   = IR[1:0];

   // Immediate byte reaches the datapath through MuxA/MuxB, not through this block
   assign unused_bits = ^{IR[7:6], Flags};

   function automatic logic [RF_W-1:0] onehot_reg(input logic [RSEL_W-1:0] idx);
      onehot_reg = RF_W'(4'b0001 << idx);
   endfunction

   // Branch decision for the current opcode; conditional forms only when enabled
   always_comb begin
      take_branch = 1'b0;
      case (opcode)
         OP_BRA: take_branch = 1'b1;
`ifdef CU_COND_BRANCH_EN
         OP_BNE: take_branch = ~Flags[3];
         OP_BEQ: take_branch = Flags[3];
`endif
         default: take_branch = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= S_FETCH_L;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH_L: state_next = S_FETCH_H;
         S_FETCH_H: state_next = S_EXEC;
         S_EXEC: begin
            if ((opcode == OP_INC) || (opcode == OP_DEC)) begin
               state_next = S_EXEC2;
            end else if (opcode == OP_HLT) begin
               state_next = S_HALT;
            end else begin
               state_next = S_FETCH_L;
            end
         end
         S_EXEC2: state_next = S_FETCH_L;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH_L;
      endcase
   end

   // Datapath control outputs; idle values first, reset holds everything idle
   always_comb begin
      RF_OutASel  = 3'b000;
      RF_OutBSel  = 3'b000;
      RF_FunSel   = 3'b000;
      RF_RegSel   = 4'b0000;
      RF_ScrSel   = 4'b0000;
      ALU_FunSel  = 5'b00000;
      ALU_WF      = 1'b0;
      ARF_OutCSel = 2'b00;
      ARF_OutDSel = 2'b00;
      ARF_FunSel  = 2'b00;
      ARF_RegSel  = 5'b00000;
      IR_LH       = 1'b0;
      IR_Write    = 1'b0;
      Mem_WR      = 1'b0;
      Mem_CS      = 1'b1;
      MuxASel     = 2'b00;
      MuxBSel     = 2'b00;
      MuxCSel     = 1'b0;
      MuxDSel     = 1'b0;
      DR_FunSel   = 2'b00;
      DR_E        = 1'b0;
      Halted      = 1'b0;

      if (!Reset) begin
         case (state)
            S_FETCH_L, S_FETCH_H: begin
               // Read byte at PC into IR half, then bump PC
               ARF_OutDSel = 2'b00;
               Mem_CS      = 1'b0;
               Mem_WR      = 1'b0;
               IR_Write    = 1'b1;
               IR_LH       = (state == S_FETCH_H);
               ARF_RegSel  = ARF_PC;
               ARF_FunSel  = ARF_INC;
            end

            S_EXEC: begin
               case (opcode)
                  OP_BRA, OP_BNE, OP_BEQ: begin
                     if (take_branch) begin
                        ARF_RegSel = ARF_PC;
                        ARF_FunSel = ARF_LOAD;
                        MuxBSel    = MUX_IR_LO;
                     end
                  end
                  OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR: begin
                     RF_OutASel = {1'b0, src1};
                     RF_OutBSel = {1'b0, src2};
                     ALU_WF     = 1'b1;
                     MuxASel    = MUX_ALUOUT;
                     RF_FunSel  = RF_LOAD;
                     RF_RegSel  = onehot_reg(dst);
                     case (opcode)
                        OP_ADD:  ALU_FunSel = ALU_ADD;
                        OP_SUB:  ALU_FunSel = ALU_SUB;
                        OP_AND:  ALU_FunSel = ALU_AND;
                        OP_ORR:  ALU_FunSel = ALU_OR;
                        default: ALU_FunSel = ALU_XOR;
                     endcase
                  end
                  OP_INC, OP_DEC: begin
                     // Copy S1 into DST; the increment/decrement happens in EXEC2
                     RF_OutASel = {1'b0, src1};
                     ALU_FunSel = ALU_PASS_A;
                     ALU_WF     = 1'b0;
                     MuxASel    = MUX_ALUOUT;
                     RF_FunSel  = RF_LOAD;
                     RF_RegSel  = onehot_reg(dst);
                  end
                  OP_MOVL: begin
                     MuxASel   = MUX_IR_LO;
                     RF_FunSel = RF_LOAD;
                     RF_RegSel = onehot_reg(rsel);
                  end
                  default: begin
                     // HLT and unused opcodes leave the datapath idle
                  end
               endcase
            end

            S_EXEC2: begin
               RF_RegSel = onehot_reg(dst);
               RF_FunSel = (opcode == OP_INC) ? RF_INC : RF_DEC;
            end

            S_HALT: begin
               Halted = 1'b1;
            end

            default: begin
            end
         endcase
      end
   end

endmodule
